// File: rtl/dm_sram_ctrl_pkg.sv
// dm_sram_ctrl_pkg: FSM state encoding, request direction and dm_* size codes.
// Also holds the misalignment rule that the DM_ALIGN_CHECK_EN build of dm_sram_ctrl uses.
package dm_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WR_HOLD,
        ST_ACK
    } state_t;

    localparam logic       DM_RW_READ  = 1'b1;
    localparam logic [3:0] DM_WBE_BYTE = 4'b1110;
    localparam logic [3:0] DM_WBE_HALF = 4'b1100;
    localparam logic [3:0] DM_WBE_WORD = 4'b0000;
    localparam logic [3:0] DM_WBE_NONE = 4'b1111;

    function automatic logic is_misaligned(input logic [3:0] wbe_n, input logic [1:0] sh);
        return (wbe_n == DM_WBE_HALF && sh[0]) || (wbe_n == DM_WBE_WORD && sh != 2'd0);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: moves right-justified store data and enables onto their byte lanes by sh.
// It also right-justifies the raw SRAM word for loads; lanes shifted past byte 3 are dropped.
module dm_lane_align (
    input  logic [1:0]  sh,
    input  logic [3:0]  wbe_n,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be_n,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_rj
);

    assign be_n     = ~(4'(~wbe_n) << sh);
    assign wdata_al = wdata << {sh, 3'b000};
    assign rdata_rj = rdata_raw >> {sh, 3'b000};

endmodule

// File: rtl/dm_sram_ctrl.sv
// dm_sram_ctrl: dm_* responder driving an asynchronous 32-bit SRAM with a wait-state FSM.
// Defining DM_ALIGN_CHECK_EN adds dm_misalign_o and rejects misaligned half/word accesses.
module dm_sram_ctrl
    import dm_sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW    = 20,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dm_req_i,
    input  logic               dm_rw_i,
    input  logic [31:0]        dm_addr_i,
    input  logic [3:0]         dm_wbe_n_i,
    input  logic [31:0]        dm_wdata_i,
    output logic [31:0]        dm_rdata_o,
    output logic               dm_ack_o,
    output logic               dm_busy_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o,
    output logic [31:0]        sram_wdata_o,
    output logic               sram_wdata_oe_o,
`ifdef DM_ALIGN_CHECK_EN
    output logic               dm_misalign_o,
`endif
    input  logic [31:0]        sram_rdata_i
);

    localparam logic [2:0] RD_LAST = 3'(READ_WAIT);
    localparam logic [2:0] WR_LAST = 3'(WRITE_WAIT);

    state_t             state, state_n;
    logic [2:0]         cnt;
    logic [1:0]         sh_q, sh;
    logic               accept, mis;
    logic [3:0]         be_al;
    logic [31:0]        wdata_al, rdata_rj;
    logic               ce_n_d, oe_n_d, we_n_d, wdata_oe_d, ack_d;
    logic [3:0]         be_n_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [31:0]        wdata_d, rdata_d;
    logic               addr_unused;

    assign addr_unused = ^dm_addr_i[31:SRAM_AW+2];
    assign accept      = dm_req_i && (state == ST_IDLE || state == ST_ACK);
    assign dm_busy_o   = state inside {ST_RD, ST_WR, ST_WR_HOLD};
    // Incoming offset aligns store data on acceptance; the latched offset aligns load data.
    assign sh          = accept ? dm_addr_i[1:0] : sh_q;

`ifdef DM_ALIGN_CHECK_EN
    assign mis = is_misaligned(dm_wbe_n_i, dm_addr_i[1:0]);
`else
    assign mis = 1'b0;
`endif

    dm_lane_align u_align (
        .sh        (sh),
        .wbe_n     (dm_wbe_n_i),
        .wdata     (dm_wdata_i),
        .rdata_raw (sram_rdata_i),
        .be_n      (be_al),
        .wdata_al  (wdata_al),
        .rdata_rj  (rdata_rj)
    );

    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
        cnt   <= (rst || state_n != state) ? 3'd0 : cnt + 3'd1;
        sh_q  <= rst ? 2'd0 : sh;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_ACK: state_n = !accept                      ? ST_IDLE :
                                       mis                          ? ST_ACK  :
                                       dm_rw_i == DM_RW_READ        ? ST_RD   :
                                       dm_wbe_n_i == DM_WBE_NONE    ? ST_ACK  : ST_WR;
            ST_RD:           state_n = cnt == RD_LAST ? ST_ACK : ST_RD;
            ST_WR:           state_n = cnt == WR_LAST ? ST_WR_HOLD : ST_WR;
            ST_WR_HOLD:      state_n = ST_ACK;
            default:         state_n = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        ce_n_d     = !(state_n inside {ST_RD, ST_WR, ST_WR_HOLD});
        oe_n_d     = state_n != ST_RD;
        we_n_d     = state_n != ST_WR;
        wdata_oe_d = state_n inside {ST_WR, ST_WR_HOLD};
        ack_d      = state_n == ST_ACK;
        be_n_d     = state_n == ST_RD                     ? 4'h0        :
                     (accept && state_n == ST_WR)         ? be_al       :
                     state_n inside {ST_WR, ST_WR_HOLD}   ? sram_be_n_o : 4'hF;
        addr_d     = accept ? dm_addr_i[SRAM_AW+1:2] : sram_addr_o;
        wdata_d    = (accept && state_n == ST_WR) ? wdata_al : sram_wdata_o;
        rdata_d    = (state == ST_RD && state_n == ST_ACK) ? rdata_rj : dm_rdata_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n_o     <= 1'b1;
            sram_oe_n_o     <= 1'b1;
            sram_we_n_o     <= 1'b1;
            sram_be_n_o     <= 4'hF;
            sram_wdata_oe_o <= 1'b0;
            sram_addr_o     <= '0;
            sram_wdata_o    <= '0;
            dm_rdata_o      <= '0;
            dm_ack_o        <= 1'b0;
        end else begin
            sram_ce_n_o     <= ce_n_d;
            sram_oe_n_o     <= oe_n_d;
            sram_we_n_o     <= we_n_d;
            sram_be_n_o     <= be_n_d;
            sram_wdata_oe_o <= wdata_oe_d;
            sram_addr_o     <= addr_d;
            sram_wdata_o    <= wdata_d;
            dm_rdata_o      <= rdata_d;
            dm_ack_o        <= ack_d;
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    always_ff @(posedge clk) dm_misalign_o <= !rst && accept && mis;
`endif

endmodule

// File: tb/tb_dm_sram_ctrl.sv
// tb_dm_sram_ctrl: randomized scoreboard bench for dm_sram_ctrl against a byte-level memory model.
module tb_dm_sram_ctrl;
    import dm_sram_ctrl_pkg::*;

    localparam int RW = 1;
    localparam int WW = 1;

    logic        clk = 1'b0, rst = 1'b1, dm_req_i = 1'b0, dm_rw_i = 1'b0;
    logic [31:0] dm_addr_i = '0, dm_wdata_i = '0, dm_rdata_o, sram_wdata_o, sram_rdata_i;
    logic [3:0]  dm_wbe_n_i = 4'hF, sram_be_n_o;
    logic        dm_ack_o, dm_busy_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_wdata_oe_o;
    logic [19:0] sram_addr_o;
`ifdef DM_ALIGN_CHECK_EN
    logic        dm_misalign_o;
`endif

    typedef struct {
        int          cyc;
        bit          chk_data;
        logic [31:0] data;
        bit          mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [31:0] mem [16];
    logic [7:0]  rb [64];
    logic [31:0] last_rd = '0, sram_w;
    logic [3:0]  sizes [4] = '{DM_WBE_BYTE, DM_WBE_HALF, DM_WBE_WORD, DM_WBE_NONE};

    dm_sram_ctrl #(.SRAM_AW(20), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk             (clk),
        .rst             (rst),
        .dm_req_i        (dm_req_i),
        .dm_rw_i         (dm_rw_i),
        .dm_addr_i       (dm_addr_i),
        .dm_wbe_n_i      (dm_wbe_n_i),
        .dm_wdata_i      (dm_wdata_i),
        .dm_rdata_o      (dm_rdata_o),
        .dm_ack_o        (dm_ack_o),
        .dm_busy_o       (dm_busy_o),
        .sram_addr_o     (sram_addr_o),
        .sram_ce_n_o     (sram_ce_n_o),
        .sram_oe_n_o     (sram_oe_n_o),
        .sram_we_n_o     (sram_we_n_o),
        .sram_be_n_o     (sram_be_n_o),
        .sram_wdata_o    (sram_wdata_o),
        .sram_wdata_oe_o (sram_wdata_oe_o),
`ifdef DM_ALIGN_CHECK_EN
        .dm_misalign_o   (dm_misalign_o),
`endif
        .sram_rdata_i    (sram_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External SRAM: lanes written while ce_n/we_n are low; garbage unless oe_n is low.
    always @(posedge clk)
        if (!sram_ce_n_o && !sram_we_n_o && sram_wdata_oe_o) begin
            sram_w = mem[sram_addr_o[3:0]];
            for (int i = 0; i < 4; i++)
                if (!sram_be_n_o[i]) sram_w[8*i +: 8] = sram_wdata_o[8*i +: 8];
            mem[sram_addr_o[3:0]] <= sram_w;
        end
    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[3:0]] : ~mem[sram_addr_o[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sz(input logic [3:0] w);
        return w == DM_WBE_BYTE ? 1 : w == DM_WBE_HALF ? 2 : w == DM_WBE_WORD ? 4 : 0;
    endfunction

    // Present a request from a negedge, hold it while busy, record the expected response.
    task automatic issue(input logic rw, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, output int t);
        exp_t e;
        int   n = 0;
        int   s = sz(w);
        bit   mis = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        mis = (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'd0);
`endif
        dm_req_i = 1'b1; dm_rw_i = rw; dm_addr_i = a; dm_wbe_n_i = w; dm_wdata_i = d;
        while (dm_busy_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (dm_busy_o) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: busy=%b after %0d cycles, required 0", dm_busy_o, n);
        end
        t          = cyc;
        e.cyc      = mis ? t + 1 : rw ? t + RW + 2 : s == 0 ? t + 1 : t + WW + 3;
        e.mis      = mis;
        e.chk_data = rw;
        e.data     = '0;
        if (rw) begin
            if (!mis) begin
                last_rd = '0;
                for (int i = 0; i < 4 - int'(a[1:0]); i++) last_rd[8*i +: 8] = rb[int'(a[5:0]) + i];
            end
            e.data = last_rd;
        end else if (!mis) begin
            for (int i = 0; i < s; i++)
                if (int'(a[1:0]) + i < 4) rb[int'(a[5:0]) + i] = d[8*i +: 8];
        end
        exp_q.push_back(e);
        @(negedge clk);
        dm_req_i = 1'b0;
    endtask

    task automatic wait_ack();
        int k = 0;
        while (!dm_ack_o && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!dm_ack_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: ack=%b after %0d cycles, required 1", dm_ack_o, k);
        end
    endtask

    always @(negedge clk)
        if (!rst && dm_ack_o) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ack: ack=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                if (e.chk_data) chk("rdata", dm_rdata_o, e.data);
`ifdef DM_ALIGN_CHECK_EN
                chk("misalign", {31'b0, dm_misalign_o}, {31'b0, e.mis});
`endif
            end
        end

    initial begin
        int t, t2, n;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++) rb[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ce_n", sram_ce_n_o, 1);
        chk("rst_oe_n", sram_oe_n_o, 1);
        chk("rst_we_n", sram_we_n_o, 1);
        chk("rst_be_n", sram_be_n_o, 4'hF);
        chk("rst_wdata_oe", sram_wdata_oe_o, 0);
        chk("rst_ack", dm_ack_o, 0);
        chk("rst_busy", dm_busy_o, 0);
        chk("rst_addr", sram_addr_o, 0);
        chk("rst_rdata", dm_rdata_o, 0);

        issue(1'b0, 32'h10, DM_WBE_WORD, 32'hDEADBEEF, t);
        chk("ww_addr", sram_addr_o, 4);
        chk("ww_be_n", sram_be_n_o, 4'h0);
        chk("ww_wdata", sram_wdata_o, 32'hDEADBEEF);
        chk("ww_oe", sram_wdata_oe_o, 1);
        chk("ww_ce_n", sram_ce_n_o, 0);
        n = 0;
        for (int k = 0; k < 20 && !dm_ack_o; k++) begin
            n += int'(!sram_we_n_o);
            @(negedge clk);
        end
        chk("we_low_cycles", n, WW + 1);

        issue(1'b1, 32'h10, DM_WBE_WORD, 32'h0, t);
        chk("rd_busy", dm_busy_o, 1);
        chk("rd_oe_n", sram_oe_n_o, 0);
        chk("rd_be_n", sram_be_n_o, 4'h0);
        issue(1'b1, 32'h10, DM_WBE_WORD, 32'h0, t2);
        chk("b2b_accept_cycle", t2, t + RW + 2);
        wait_ack();
        chk("word_rdata", dm_rdata_o, 32'hDEADBEEF);

        issue(1'b0, 32'h13, DM_WBE_BYTE, 32'h0000_00A5, t);
        chk("bw_be_n", sram_be_n_o, 4'b0111);
        chk("bw_wdata", sram_wdata_o, 32'hA500_0000);
        wait_ack();
        issue(1'b1, 32'h13, DM_WBE_BYTE, 32'h0, t);
        wait_ack();
        chk("byte_rdata", dm_rdata_o, 32'h0000_00A5);

        issue(1'b0, 32'h8, DM_WBE_NONE, 32'h1234_5678, t);
        chk("none_ce_n", sram_ce_n_o, 1);
        chk("none_ack", dm_ack_o, 1);

        issue(1'b0, 32'h20, DM_WBE_WORD, 32'h1234_5678, t);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we_n", sram_we_n_o, 1);
        chk("abort_wdata_oe", sram_wdata_oe_o, 0);
        chk("abort_busy", dm_busy_o, 0);
        chk("abort_ack", dm_ack_o, 0);
        exp_q.delete();
        last_rd = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_ack", dm_ack_o, 0);

`ifdef DM_ALIGN_CHECK_EN
        issue(1'b1, 32'h01, DM_WBE_HALF, 32'h0, t);
        chk("mis_ce_n", sram_ce_n_o, 1);
        chk("mis_flag", dm_misalign_o, 1);
`endif

        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), sizes[$urandom_range(0, 3)],
                  $urandom, t);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("outstanding_acks", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
